// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Drives an 8-LED bank with one of four patterns: walk, bounce, binary count
//   or blink. A free-running prescaler sets the step rate. Pattern changes
//   arrive on a valid/ready port. A change is held pending and takes effect
//   only on the next step boundary.
// Ports
//   clk, rst         system clock; synchronous active-high reset
//   mode_req_valid   request a pattern change
//   mode_req[1:0]    requested pattern: 0 WALK, 1 BOUNCE, 2 COUNT, 3 BLINK
//   mode_req_ready   high while no request is pending
//   pause            freezes the prescaler, and therefore the pattern
//   tick             one-cycle pulse; the edge that sees it performs a step
//   mode[1:0]        pattern currently displayed
//   leds[7:0]        LED bank, 1 = on
module led_pattern_sequencer #(
   parameter int LOG2DELAY = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_req_valid,
   input  logic [1:0] mode_req,
   output logic       mode_req_ready,
   input  logic       pause,
   output logic       tick,
   output logic [1:0] mode,
   output logic [7:0] leds
);

   localparam logic [1:0] M_WALK   = 2'd0;
   localparam logic [1:0] M_BOUNCE = 2'd1;
   localparam logic [1:0] M_COUNT  = 2'd2;
   localparam logic [1:0] M_BLINK  = 2'd3;
   localparam logic [LOG2DELAY-1:0] PRESC_ONE = LOG2DELAY'(1);

   typedef enum logic [0:0] {ST_RUN, ST_PENDING} state_t;

   state_t               state_q, state_d;
   logic [LOG2DELAY-1:0] presc_q, presc_d;
   logic                 tick_q, tick_d;
   logic [1:0]           mode_q, mode_d;
   logic [1:0]           pend_q, pend_d;
   logic [7:0]           leds_q, leds_d;
   logic                 dir_up_q, dir_up_d;
   logic                 dir_eff;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         presc_q  <= '0;
         tick_q   <= 1'b0;
         mode_q   <= M_WALK;
         pend_q   <= M_WALK;
         leds_q   <= 8'h01;
         dir_up_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         tick_q   <= tick_d;
         mode_q   <= mode_d;
         pend_q   <= pend_d;
         leds_q   <= leds_d;
         dir_up_q <= dir_up_d;
      end
   end

   always_comb begin
      presc_d  = presc_q;
      tick_d   = 1'b0;
      state_d  = state_q;
      mode_d   = mode_q;
      pend_d   = pend_q;
      leds_d   = leds_q;
      dir_up_d = dir_up_q;
      dir_eff  = dir_up_q;

      // Tick is raised for the cycle after the all-ones -> zero wrap.
      if (!pause) begin
         presc_d = presc_q + PRESC_ONE;
         tick_d  = (presc_q == '1);
      end

      // The step uses tick_q, not pause. A tick that is already raised is
      // consumed even if pause rises in the same cycle.
      if (tick_q && state_q == ST_PENDING) begin
         mode_d  = pend_q;
         state_d = ST_RUN;
         unique case (pend_q)
            M_WALK:   leds_d = 8'h01;
            M_BOUNCE: begin leds_d = 8'h01; dir_up_d = 1'b1; end
            M_COUNT:  leds_d = 8'h00;
            default:  leds_d = 8'hFF;
         endcase
      end else if (tick_q) begin
         unique case (mode_q)
            M_WALK:   leds_d = {leds_q[6:0], leds_q[7]};
            M_BOUNCE: begin
               // Turn around at an end LED so that it shows for only one step.
               if (leds_q == 8'h80)      dir_eff = 1'b0;
               else if (leds_q == 8'h01) dir_eff = 1'b1;
               leds_d   = dir_eff ? {leds_q[6:0], 1'b0} : {1'b0, leds_q[7:1]};
               dir_up_d = dir_eff;
            end
            M_COUNT:  leds_d = leds_q + 8'd1;
            default:  leds_d = ~leds_q;
         endcase
      end

      // A request accepted on a tick edge does not affect that step.
      if (state_q == ST_RUN && mode_req_valid) begin
         pend_d  = mode_req;
         state_d = ST_PENDING;
      end
   end

   assign mode_req_ready = (state_q == ST_RUN);
   assign tick           = tick_q;
   assign mode           = mode_q;
   assign leds           = leds_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
module tb_led_pattern_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode_req_valid = 1'b0;
   logic [1:0] mode_req = 2'd0;
   logic       mode_req_ready;
   logic       pause = 1'b0;
   logic       tick;
   logic [1:0] mode;
   logic [7:0] leds;

   int checks = 0;
   int errors = 0;

   led_pattern_sequencer #(.LOG2DELAY(2)) dut (
      .clk(clk), .rst(rst), .mode_req_valid(mode_req_valid), .mode_req(mode_req),
      .mode_req_ready(mode_req_ready), .pause(pause), .tick(tick), .mode(mode), .leds(leds)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state. The pattern is held as "steps since seed" and the
   // prescaler as a count of unpaused cycles since reset.
   bit      m_on = 0;
   int      m_cnt, m_phase;
   bit      m_tick, m_pending;
   int      m_mode, m_pend;

   function automatic int bounce_at(input int p);
      int k;
      k = p % 14;
      return (k <= 7) ? (1 << k) : (1 << (14 - k));
   endfunction

   function automatic int exp_leds(input int md, input int p);
      case (md)
         0:       return 1 << (p % 8);
         1:       return bounce_at(p);
         2:       return p % 256;
         default: return (p % 2 == 0) ? 8'hFF : 8'h00;
      endcase
   endfunction

   always @(posedge clk) begin
      bit was_tick, was_ready;
      if (rst) begin
         m_on = 1; m_cnt = 0; m_tick = 0; m_mode = 0; m_phase = 0; m_pending = 0; m_pend = 0;
      end else if (m_on) begin
         was_tick  = m_tick;
         was_ready = !m_pending;
         if (was_tick) begin
            if (m_pending) begin
               m_mode = m_pend; m_phase = 0; m_pending = 0;
            end else begin
               m_phase++;
            end
         end
         if (mode_req_valid && was_ready) begin
            m_pending = 1; m_pend = int'(mode_req);
         end
         m_tick = 0;
         if (!pause) begin
            m_cnt++;
            m_tick = (m_cnt % 4 == 0);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (m_on) begin
         chk("mdl_tick",  int'(tick), int'(m_tick));
         chk("mdl_ready", int'(mode_req_ready), int'(!m_pending));
         chk("mdl_mode",  int'(mode), m_mode);
         chk("mdl_leds",  int'(leds), exp_leds(m_mode, m_phase));
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns at a negedge where tick=1, so the next posedge is a step edge.
   task automatic wait_tick();
      for (int i = 0; i < 20; i++) begin
         if (tick === 1'b1) return;
         @(negedge clk);
      end
      chk("tick_timeout", 0, 1);
   endtask

   task automatic request(input logic [1:0] m);
      for (int i = 0; i < 20; i++) begin
         if (mode_req_ready === 1'b1) break;
         @(negedge clk);
      end
      mode_req = m; mode_req_valid = 1'b1;
      @(negedge clk);
      mode_req_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      idle(2);
      chk("rst_leds", int'(leds), 8'h01);
      chk("rst_mode", int'(mode), 0);
      chk("rst_ready", int'(mode_req_ready), 1);
      chk("rst_tick", int'(tick), 0);
      rst = 1'b0;

      // 1: walk. The first tick comes four cycles after release.
      idle(4);
      chk("first_tick", int'(tick), 1);
      idle(1);
      chk("walk_step1", int'(leds), 8'h02);
      idle(36);

      // 2: bounce request. Ready drops, then the seed lands on the next tick.
      wait_tick(); idle(1);
      request(2'd1);
      chk("req_ready_low", int'(mode_req_ready), 0);
      wait_tick(); idle(1);
      chk("bounce_seed", int'(leds), 8'h01);
      chk("bounce_mode", int'(mode), 1);
      chk("bounce_ready", int'(mode_req_ready), 1);
      idle(4 * 15);

      // 3: count wraps FF -> 00, then blink.
      request(2'd2);
      idle(4 * 262);
      request(2'd3);
      idle(24);

      // 4: accept on a tick edge, then a dropped second valid.
      wait_tick();
      mode_req = 2'd0; mode_req_valid = 1'b1;
      idle(1);
      mode_req_valid = 1'b0;
      chk("tick_accept_mode", int'(mode), 3);
      chk("tick_accept_ready", int'(mode_req_ready), 0);
      idle(1);
      mode_req_valid = 1'b1;
      idle(1);
      mode_req_valid = 1'b0;
      wait_tick(); idle(1);
      chk("tick_accept_seed_mode", int'(mode), 0);
      chk("tick_accept_seed_leds", int'(leds), 8'h01);
      idle(8);

      // 5: pause with a request pending
      request(2'd1);
      pause = 1'b1;
      idle(20);
      chk("pause_mode", int'(mode), 0);
      chk("pause_ready", int'(mode_req_ready), 0);
      pause = 1'b0;
      wait_tick(); idle(1);
      chk("pause_seed_mode", int'(mode), 1);
      chk("pause_seed_leds", int'(leds), 8'h01);
      idle(4 * 5);

      // 6: reset while a request is pending in the middle of a bounce
      request(2'd2);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("rst6_leds", int'(leds), 8'h01);
      chk("rst6_mode", int'(mode), 0);
      chk("rst6_ready", int'(mode_req_ready), 1);
      chk("rst6_tick", int'(tick), 0);
      idle(24);
      chk("rst6_lost_mode", int'(mode), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
